// File: rtl/tmr_irq_controller_if.sv
// CPU-side and timer-side signal bundle for the timer interrupt controller.
// The controller attaches through the slave modport; the driver of requests/handshake uses master.
interface tmr_irq_controller_if #(
   parameter int NUM_SRC  = 6,
   parameter int ID_WIDTH = 3
);
   logic                CMIA0;
   logic                CMIB0;
   logic                OVI0;
   logic                CMIA1;
   logic                CMIB1;
   logic                OVI1;
   logic                int_en;
   logic [NUM_SRC-1:0]  src_mask;
   logic                irq_ack;
   logic                irq_eoi;
   logic                irq;
   logic [ID_WIDTH-1:0] irq_id;
   logic [7:0]          irq_vector;
   logic                in_service;
   logic [NUM_SRC-1:0]  pending;

   modport slave (
      input  CMIA0, CMIB0, OVI0, CMIA1, CMIB1, OVI1,
      input  int_en, src_mask, irq_ack, irq_eoi,
      output irq, irq_id, irq_vector, in_service, pending
   );

   modport master (
      output CMIA0, CMIB0, OVI0, CMIA1, CMIB1, OVI1,
      output int_en, src_mask, irq_ack, irq_eoi,
      input  irq, irq_id, irq_vector, in_service, pending
   );
endinterface

// File: rtl/tmr_irq_controller.sv
// Registers the six 8-bit timer interrupt levels, picks one by fixed priority and
// runs the irq / ack / eoi handshake with the CPU.
module tmr_irq_controller #(
   parameter int         NUM_SRC     = 6,
   parameter int         ID_WIDTH    = 3,
   parameter logic [7:0] VECTOR_BASE = 8'd64
) (
   input  logic                 clk,
   input  logic                 rst,
   tmr_irq_controller_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ASSERT  = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [NUM_SRC-1:0]  req_q, req_d;
   logic [NUM_SRC-1:0]  win_q, win_d;
   logic [ID_WIDTH-1:0] irq_id_q, irq_id_d;

   logic [NUM_SRC-1:0]  pending_w;
   logic [NUM_SRC-1:0]  arb_oh;
   logic [ID_WIDTH-1:0] arb_id;
   logic                presented_live;

   // Source bit i maps to channel i/3, kind i%3; ids leave a gap at 3.
   function automatic logic [ID_WIDTH-1:0] src_id(input int i);
      return ID_WIDTH'((i / 3) * 4 + (i % 3));
   endfunction

   assign req_d     = {bus.OVI1, bus.CMIB1, bus.CMIA1, bus.OVI0, bus.CMIB0, bus.CMIA0};
   assign pending_w = req_q & ~bus.src_mask;

   // Lowest bit index wins: the descending loop lets the last hit override.
   always_comb begin
      arb_oh = '0;
      arb_id = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (pending_w[i]) begin
            arb_oh    = '0;
            arb_oh[i] = 1'b1;
            arb_id    = src_id(i);
         end
      end
   end

   assign presented_live = |(pending_w & win_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         req_q    <= '0;
         win_q    <= '0;
         irq_id_q <= '0;
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         win_q    <= win_d;
         irq_id_q <= irq_id_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      win_d    = win_q;
      irq_id_d = irq_id_q;
      case (state_q)
         IDLE: begin
            if (bus.int_en && (|pending_w)) begin
               state_d  = ASSERT;
               win_d    = arb_oh;
               irq_id_d = arb_id;
            end
         end
         ASSERT: begin
            // Ack beats a same-cycle withdrawal; later arrivals never pre-empt.
            if (bus.irq_ack)
               state_d = SERVICE;
            else if (!bus.int_en || !presented_live)
               state_d = IDLE;
         end
         SERVICE: begin
            if (bus.irq_eoi)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.irq        = (state_q == ASSERT);
      bus.in_service = (state_q == SERVICE);
      bus.irq_id     = irq_id_q;
      bus.irq_vector = VECTOR_BASE + {{(8 - ID_WIDTH){1'b0}}, irq_id_q};
      bus.pending    = pending_w;
   end

endmodule

// File: tb/tb_tmr_irq_controller.sv
// Directed bench for tmr_irq_controller: hand-computed expectations checked with
// immediate assertions after each rising edge.
module tb_tmr_irq_controller;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   tmr_irq_controller_if #(.NUM_SRC(6), .ID_WIDTH(3)) bus ();

   tmr_irq_controller #(.NUM_SRC(6), .ID_WIDTH(3), .VECTOR_BASE(8'd64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_reqs(input logic [5:0] r);
      {bus.OVI1, bus.CMIB1, bus.CMIA1, bus.OVI0, bus.CMIB0, bus.CMIA0} = r;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      set_reqs(6'h00);
      bus.int_en   = 1'b1;
      bus.src_mask = 6'h00;
      bus.irq_ack  = 1'b0;
      bus.irq_eoi  = 1'b0;
      tick(2);
      chk("rst_irq", bus.irq, 1'b0);
      chk("rst_id", bus.irq_id, 3'd0);
      chk("rst_vec", bus.irq_vector, 8'd64);
      chk("rst_insvc", bus.in_service, 1'b0);
      chk("rst_pend", bus.pending, 6'h00);
      rst = 1'b0;
      tick(1);

      // OVI0 held: two-cycle latency, ack, eoi.
      set_reqs(6'h04);
      tick(1);
      chk("t1_pend", bus.pending, 6'h04);
      chk("t1_irq_lat1", bus.irq, 1'b0);
      tick(1);
      chk("t1_irq", bus.irq, 1'b1);
      chk("t1_id", bus.irq_id, 3'd2);
      chk("t1_vec", bus.irq_vector, 8'd66);
      bus.irq_ack = 1'b1;
      tick(1);
      bus.irq_ack = 1'b0;
      chk("t1_ack_irq", bus.irq, 1'b0);
      chk("t1_ack_insvc", bus.in_service, 1'b1);
      set_reqs(6'h00);
      bus.irq_eoi = 1'b1;
      tick(1);
      bus.irq_eoi = 1'b0;
      chk("t1_eoi_insvc", bus.in_service, 1'b0);
      chk("t1_eoi_irq", bus.irq, 1'b0);
      tick(1);
      chk("t1_idle_irq", bus.irq, 1'b0);

      // CMIB1 and CMIA0 together: CMIA0 first, then CMIB1 right after eoi.
      set_reqs(6'h11);
      tick(2);
      chk("t2_irq", bus.irq, 1'b1);
      chk("t2_id", bus.irq_id, 3'd0);
      chk("t2_vec", bus.irq_vector, 8'd64);
      bus.irq_ack = 1'b1;
      tick(1);
      bus.irq_ack = 1'b0;
      chk("t2_insvc", bus.in_service, 1'b1);
      chk("t2_pend_svc", bus.pending, 6'h11);
      set_reqs(6'h10);
      bus.irq_eoi = 1'b1;
      tick(1);
      bus.irq_eoi = 1'b0;
      chk("t2_eoi_irq", bus.irq, 1'b0);
      chk("t2_eoi_insvc", bus.in_service, 1'b0);
      tick(1);
      chk("t2_next_irq", bus.irq, 1'b1);
      chk("t2_next_id", bus.irq_id, 3'd5);
      chk("t2_next_vec", bus.irq_vector, 8'd69);
      set_reqs(6'h00);
      tick(2);
      chk("t2_withdraw", bus.irq, 1'b0);

      // CMIA1 drops before ack: withdraw, then a stray ack is ignored.
      set_reqs(6'h08);
      tick(2);
      chk("t3_irq", bus.irq, 1'b1);
      chk("t3_id", bus.irq_id, 3'd4);
      set_reqs(6'h00);
      tick(1);
      chk("t3_hold", bus.irq, 1'b1);
      tick(1);
      chk("t3_drop", bus.irq, 1'b0);
      bus.irq_ack = 1'b1;
      tick(1);
      bus.irq_ack = 1'b0;
      chk("t3_ack_ign_insvc", bus.in_service, 1'b0);
      chk("t3_ack_ign_irq", bus.irq, 1'b0);

      // int_en low with everything pending, then masked down to CMIA0.
      bus.int_en = 1'b0;
      set_reqs(6'h3F);
      tick(2);
      chk("t4_irq_dis", bus.irq, 1'b0);
      chk("t4_pend", bus.pending, 6'h3F);
      bus.src_mask = 6'h3E;
      bus.int_en   = 1'b1;
      tick(1);
      chk("t4_irq", bus.irq, 1'b1);
      chk("t4_id", bus.irq_id, 3'd0);
      chk("t4_pend_mask", bus.pending, 6'h01);
      bus.irq_ack = 1'b1;
      tick(1);
      bus.irq_ack = 1'b0;
      set_reqs(6'h00);
      bus.src_mask = 6'h00;
      bus.irq_eoi  = 1'b1;
      tick(1);
      bus.irq_eoi = 1'b0;
      chk("t4_eoi_insvc", bus.in_service, 1'b0);
      tick(1);
      chk("t4_idle_irq", bus.irq, 1'b0);

      // Mask the presented source during ASSERT: withdraw.
      set_reqs(6'h01);
      tick(2);
      chk("t4m_irq", bus.irq, 1'b1);
      bus.src_mask = 6'h01;
      tick(1);
      chk("t4m_withdraw", bus.irq, 1'b0);
      set_reqs(6'h00);
      bus.src_mask = 6'h00;
      tick(2);

      // Request held through eoi: re-presented; reset during SERVICE.
      set_reqs(6'h02);
      tick(2);
      chk("t5_id", bus.irq_id, 3'd1);
      bus.irq_ack = 1'b1;
      tick(1);
      bus.irq_ack = 1'b0;
      bus.irq_eoi = 1'b1;
      tick(1);
      bus.irq_eoi = 1'b0;
      chk("t5_gap_irq", bus.irq, 1'b0);
      chk("t5_gap_insvc", bus.in_service, 1'b0);
      tick(1);
      chk("t5_rep_irq", bus.irq, 1'b1);
      chk("t5_rep_id", bus.irq_id, 3'd1);
      bus.irq_ack = 1'b1;
      tick(1);
      bus.irq_ack = 1'b0;
      chk("t5_svc", bus.in_service, 1'b1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("t5_rst_insvc", bus.in_service, 1'b0);
      chk("t5_rst_irq", bus.irq, 1'b0);
      chk("t5_rst_vec", bus.irq_vector, 8'd64);
      chk("t5_rst_pend", bus.pending, 6'h00);
      set_reqs(6'h00);
      tick(2);

      // Ack and source drop together: ack wins.
      set_reqs(6'h20);
      tick(2);
      chk("t6_id", bus.irq_id, 3'd6);
      chk("t6_vec", bus.irq_vector, 8'd70);
      bus.irq_ack = 1'b1;
      set_reqs(6'h00);
      tick(1);
      bus.irq_ack = 1'b0;
      chk("t6_ackwin", bus.in_service, 1'b1);
      chk("t6_ackwin_id", bus.irq_id, 3'd6);
      bus.irq_eoi = 1'b1;
      tick(1);
      bus.irq_eoi = 1'b0;
      chk("t6_eoi", bus.in_service, 1'b0);

      // eoi in ASSERT is ignored; ack+eoi together acts as ack only.
      set_reqs(6'h04);
      tick(2);
      bus.irq_eoi = 1'b1;
      tick(1);
      bus.irq_eoi = 1'b0;
      chk("t6_eoi_ign_irq", bus.irq, 1'b1);
      chk("t6_eoi_ign_insvc", bus.in_service, 1'b0);
      bus.irq_ack = 1'b1;
      bus.irq_eoi = 1'b1;
      tick(1);
      bus.irq_ack = 1'b0;
      bus.irq_eoi = 1'b0;
      chk("t6_both_insvc", bus.in_service, 1'b1);
      tick(1);
      chk("t6_both_stay", bus.in_service, 1'b1);
      set_reqs(6'h00);
      bus.irq_eoi = 1'b1;
      tick(1);
      bus.irq_eoi = 1'b0;
      chk("t6_final", bus.in_service, 1'b0);
      tick(1);
      chk("t6_final_irq", bus.irq, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
